// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase and BCD counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLap,
    StStop
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam int unsigned ModMsecl = 10;
  localparam int unsigned ModMsech = 10;
  localparam int unsigned ModSecl  = 10;
  localparam int unsigned ModSech  = 6;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade-style BCD digit with synchronous clear and cascade carry.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MOD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t Max = bcd_t'(MOD - 1);

  if ((MOD < 2) || (MOD > 10)) begin : g_bad_mod
    $error("bcd_digit_counter MOD must be in 2..10");
  end

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      // >= keeps the digit in range even if it were ever disturbed
      q_d = (q_q >= Max) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == Max);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: 100 Hz prescaler, 00.00-59.99 BCD count, start/stop/lap/clear FSM, display hold.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_stop,
  input  logic lap,
  input  logic clear,
  output bcd_t stopwatchsech,
  output bcd_t stopwatchsecl,
  output bcd_t stopwatchmsech,
  output bcd_t stopwatchmsecl,
  output logic running,
  output logic lap_active,
  output logic overflow
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PsW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(DIV - 1);

  if (((CLK_HZ % TICK_HZ) != 0) || (DIV == 0)) begin : g_bad_div
    $error("CLK_HZ must be a nonzero integer multiple of TICK_HZ");
  end

  sw_state_e      state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [15:0]    disp_q, disp_d;
  logic           running_q, lap_active_q, overflow_q;
  logic           counting, tick, clr_cnt;
  bcd_t           cnt_msecl, cnt_msech, cnt_secl, cnt_sech;
  logic           c_msecl, c_msech, c_secl, wrap;

  // Priority clear > start_stop > lap, restricted to pulses valid in each state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_stop) state_d = StRun;
      StRun: begin
        if (start_stop) state_d = StStop;
        else if (lap)   state_d = StLap;
      end
      StLap: begin
        if (start_stop) state_d = StStop;
        else if (lap)   state_d = StRun;
      end
      StStop: begin
        if (clear)           state_d = StIdle;
        else if (start_stop) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PsMax);
  assign clr_cnt  = (state_q == StStop) && clear;

  always_comb begin
    presc_d = presc_q;
    if ((state_q == StIdle) || clr_cnt) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  bcd_digit_counter #(.MOD(ModMsecl)) u_msecl (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(tick), .q(cnt_msecl), .carry(c_msecl)
  );
  bcd_digit_counter #(.MOD(ModMsech)) u_msech (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(c_msecl), .q(cnt_msech), .carry(c_msech)
  );
  bcd_digit_counter #(.MOD(ModSecl)) u_secl (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(c_msech), .q(cnt_secl), .carry(c_secl)
  );
  bcd_digit_counter #(.MOD(ModSech)) u_sech (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(c_secl), .q(cnt_sech), .carry(wrap)
  );

  // The lap snapshot is simply the last load before entering LAP, so a same-edge tick is excluded
  assign disp_d = (state_q == StLap) ? disp_q : {cnt_sech, cnt_secl, cnt_msech, cnt_msecl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      disp_q       <= disp_d;
      running_q    <= (state_d == StRun) || (state_d == StLap);
      lap_active_q <= (state_d == StLap);
      overflow_q   <= clr_cnt ? 1'b0 : (overflow_q | wrap);
    end
  end

  assign stopwatchsech  = disp_q[15:12];
  assign stopwatchsecl  = disp_q[11:8];
  assign stopwatchmsech = disp_q[7:4];
  assign stopwatchmsecl = disp_q[3:0];
  assign running        = running_q;
  assign lap_active     = lap_active_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;
  logic [3:0] sech, secl, msech, msecl;
  logic running, lap_active, overflow;

  int checks = 0;
  int failures = 0;

  // Packed {0, running, lap_active, overflow, sech, secl, msech, msecl}
  logic [19:0] exp_q[$];
  logic [19:0] e;

  stopwatch_core #(
    .CLK_HZ(1000),
    .TICK_HZ(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_stop(start_stop),
    .lap(lap),
    .clear(clear),
    .stopwatchsech(sech),
    .stopwatchsecl(secl),
    .stopwatchmsech(msech),
    .stopwatchmsecl(msecl),
    .running(running),
    .lap_active(lap_active),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] obs();
    return {1'b0, running, lap_active, overflow, sech, secl, msech, msecl};
  endfunction

  function automatic logic [19:0] mk(input logic [15:0] d, input logic r, input logic l,
                                     input logic o);
    return {1'b0, r, l, o, d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse is sampled at the next rising edge; returns just after that edge
  task automatic pulse(input logic s, input logic l, input logic c);
    start_stop = s;
    lap = l;
    clear = c;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    #1 rst_n = 1'b0;
    #2;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(), e); end
    @(negedge clk) rst_n = 1'b1;
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs(), e); end
    step(30);
    pulse(0, 1, 0);
    step(30);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL idle_lap_ignored got=%h exp=%h", obs(), e); end
    pulse(0, 0, 1);
    step(38);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL idle_clear_ignored got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_run();
    exp_q.push_back(mk(16'h0000, 1, 0, 0));
    exp_q.push_back(mk(16'h0001, 1, 0, 0));
    exp_q.push_back(mk(16'h0099, 1, 0, 0));
    exp_q.push_back(mk(16'h0100, 1, 0, 0));
    exp_q.push_back(mk(16'h0100, 0, 0, 0));
    exp_q.push_back(mk(16'h0100, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(10);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_first_tick_lag got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_first_tick got=%h exp=%h", obs(), e); end
    for (int i = 0; i < 989; i++) begin
      step(1);
      checks++;
      if (running !== 1'b1) begin
        failures++;
        $display("FAIL run_running cycle=%0d got=%b exp=1", i, running);
      end
    end
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_before_100 got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_100_ticks got=%h exp=%h", obs(), e); end
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_stop got=%h exp=%h", obs(), e); end
    pulse(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_clear_lag got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL run_clear got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_stop_resume();
    exp_q.push_back(mk(16'h0025, 0, 0, 0));
    exp_q.push_back(mk(16'h0025, 0, 0, 0));
    exp_q.push_back(mk(16'h0025, 1, 0, 0));
    exp_q.push_back(mk(16'h0029, 1, 0, 0));
    exp_q.push_back(mk(16'h0030, 1, 0, 0));
    exp_q.push_back(mk(16'h0030, 1, 0, 0));
    exp_q.push_back(mk(16'h0031, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(254);
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_stop_25 got=%h exp=%h", obs(), e); end
    step(500);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_pause_hold got=%h exp=%h", obs(), e); end
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_resume got=%h exp=%h", obs(), e); end
    step(45);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_phase_pre got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_reads_30 got=%h exp=%h", obs(), e); end
    step(9);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_no_extra_tick got=%h exp=%h", obs(), e); end
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_clear_edge got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sr_clear got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_lap();
    exp_q.push_back(mk(16'h0042, 1, 1, 0));
    exp_q.push_back(mk(16'h0042, 1, 1, 0));
    exp_q.push_back(mk(16'h0042, 1, 0, 0));
    exp_q.push_back(mk(16'h0060, 1, 0, 0));
    exp_q.push_back(mk(16'h0060, 0, 0, 0));
    exp_q.push_back(mk(16'h0063, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(429);
    pulse(0, 1, 0);  // sampled on the edge of tick 43
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_snapshot got=%h exp=%h", obs(), e); end
    step(174);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_frozen got=%h exp=%h", obs(), e); end
    pulse(0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_release_edge got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_release got=%h exp=%h", obs(), e); end
    pulse(0, 1, 0);
    step(30);
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_stop_edge got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_stop_live got=%h exp=%h", obs(), e); end
    pulse(0, 0, 1);
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL lap_clear got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_overflow();
    exp_q.push_back(mk(16'h5999, 1, 0, 0));
    exp_q.push_back(mk(16'h5999, 1, 0, 1));
    exp_q.push_back(mk(16'h0000, 1, 0, 1));
    exp_q.push_back(mk(16'h0005, 1, 0, 1));
    exp_q.push_back(mk(16'h0005, 0, 0, 1));
    exp_q.push_back(mk(16'h0005, 0, 0, 1));
    exp_q.push_back(mk(16'h0005, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(59991);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_5999 got=%h exp=%h", obs(), e); end
    step(9);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_wrap_edge got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_wrap_disp got=%h exp=%h", obs(), e); end
    step(50);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_sticky got=%h exp=%h", obs(), e); end
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_stop got=%h exp=%h", obs(), e); end
    pulse(0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_stop_lap_ignored got=%h exp=%h", obs(), e); end
    pulse(0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_clear got=%h exp=%h", obs(), e); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL ov_clear_disp got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(mk(16'h0003, 0, 0, 0));
    exp_q.push_back(mk(16'h0003, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    exp_q.push_back(mk(16'h0005, 0, 0, 0));
    exp_q.push_back(mk(16'h0005, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(30);
    pulse(1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_stop got=%h exp=%h", obs(), e); end
    pulse(1, 1, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_all_stop got=%h exp=%h", obs(), e); end
    step(20);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_all_idle got=%h exp=%h", obs(), e); end
    pulse(1, 0, 0);
    step(50);
    pulse(1, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_ss_lap_run got=%h exp=%h", obs(), e); end
    step(20);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_ss_lap_held got=%h exp=%h", obs(), e); end
    pulse(0, 0, 1);
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL sim_clear got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_async_reset();
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    exp_q.push_back(mk(16'h0000, 0, 0, 0));
    pulse(1, 0, 0);
    step(35);
    #2 rst_n = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL arst_mid_run got=%h exp=%h", obs(), e); end
    @(negedge clk) rst_n = 1'b1;
    step(20);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL arst_idle_after got=%h exp=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop_resume();
    test_lap();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
